// File: rtl/oldland_bus_arbiter.sv
// Round-robin arbiter sharing the external memory bus between the fetch and data ports.
// A per-transaction watchdog turns an unanswered bus cycle into an error on the owning port.
module oldland_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_access,
   input  logic [31:0] i_addr,
   output logic [31:0] i_data,
   output logic        i_ack,
   output logic        i_error,
   input  logic        d_access,
   input  logic [31:0] d_addr,
   input  logic        d_wr_en,
   input  logic [31:0] d_wr_val,
   input  logic [3:0]  d_bytesel,
   output logic [31:0] d_data,
   output logic        d_ack,
   output logic        d_error,
   output logic        m_access,
   output logic [31:0] m_addr,
   output logic        m_wr_en,
   output logic [31:0] m_wr_val,
   output logic [3:0]  m_bytesel,
   input  logic [31:0] m_data,
   input  logic        m_ack,
   input  logic        m_error
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t      state_r;
   state_t      state_next_s;
   logic        last_grant_r;
   logic [15:0] cnt_r;
   logic        granted_s;
   logic        timeout_s;
   logic        done_s;

   // Watchdog only fires when the slave has said nothing this cycle, so ack/error take priority.
   always_comb begin
      granted_s = (state_r == ST_GRANT_I) || (state_r == ST_GRANT_D);
      timeout_s = granted_s && (cnt_r == TIMEOUT_LIMIT) && !m_ack && !m_error;
      done_s    = granted_s && (m_ack || m_error || timeout_s);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state: contended requests go to the port that did not win last time.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_access && d_access) begin
               state_next_s = last_grant_r ? ST_GRANT_I : ST_GRANT_D;
            end else if (i_access) begin
               state_next_s = ST_GRANT_I;
            end else if (d_access) begin
               state_next_s = ST_GRANT_D;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_GRANT_I, ST_GRANT_D: begin
            if (done_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bus request registers, grant history and watchdog counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_access     <= 1'b0;
         m_addr       <= 32'h0000_0000;
         m_wr_en      <= 1'b0;
         m_wr_val     <= 32'h0000_0000;
         m_bytesel    <= 4'h0;
         last_grant_r <= 1'b1;
         cnt_r        <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (state_next_s == ST_GRANT_I) begin
                  m_access     <= 1'b1;
                  m_addr       <= i_addr;
                  m_wr_en      <= 1'b0;
                  m_wr_val     <= 32'h0000_0000;
                  m_bytesel    <= 4'hF;
                  last_grant_r <= 1'b0;
                  cnt_r        <= 16'h0000;
               end else if (state_next_s == ST_GRANT_D) begin
                  m_access     <= 1'b1;
                  m_addr       <= d_addr;
                  m_wr_en      <= d_wr_en;
                  m_wr_val     <= d_wr_val;
                  m_bytesel    <= d_bytesel;
                  last_grant_r <= 1'b1;
                  cnt_r        <= 16'h0000;
               end
            end
            ST_GRANT_I, ST_GRANT_D: begin
               if (done_s) begin
                  m_access <= 1'b0;
                  m_wr_en  <= 1'b0;
               end else if (cnt_r != 16'hFFFF) begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               m_access <= 1'b0;
               m_wr_en  <= 1'b0;
            end
         endcase
      end
   end

   // Completion and read data are routed straight from the slave to the owning port only.
   always_comb begin
      i_ack   = 1'b0;
      i_error = 1'b0;
      i_data  = 32'h0000_0000;
      d_ack   = 1'b0;
      d_error = 1'b0;
      d_data  = 32'h0000_0000;
      case (state_r)
         ST_GRANT_I: begin
            i_ack   = m_ack;
            i_error = (!m_ack && m_error) || timeout_s;
            i_data  = m_data;
         end
         ST_GRANT_D: begin
            d_ack   = m_ack;
            d_error = (!m_ack && m_error) || timeout_s;
            d_data  = m_data;
         end
         default: begin
            i_ack = 1'b0;
            d_ack = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Directed, table-driven bench for oldland_bus_arbiter with a 4-cycle watchdog.
module tb_oldland_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_access;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_ack;
   logic        i_error;
   logic        d_access;
   logic [31:0] d_addr;
   logic        d_wr_en;
   logic [31:0] d_wr_val;
   logic [3:0]  d_bytesel;
   logic [31:0] d_data;
   logic        d_ack;
   logic        d_error;
   logic        m_access;
   logic [31:0] m_addr;
   logic        m_wr_en;
   logic [31:0] m_wr_val;
   logic [3:0]  m_bytesel;
   logic [31:0] m_data;
   logic        m_ack;
   logic        m_error;

   int errors = 0;
   int checks = 0;

   oldland_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_error(i_error),
      .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_wr_val(d_wr_val),
      .d_bytesel(d_bytesel), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
      .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_wr_val(m_wr_val),
      .m_bytesel(m_bytesel), .m_data(m_data), .m_ack(m_ack), .m_error(m_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ia; logic [31:0] iaddr; logic da; logic [31:0] daddr; logic dwe; logic [31:0] dwv;
      logic [3:0] dbs; logic [31:0] mdata; logic mack; logic merr;
      logic macc; logic [31:0] maddr; logic mwe; logic [31:0] mwv; logic [3:0] mbs;
      logic iack; logic ierr; logic [31:0] idata; logic dack; logic derr; logic [31:0] ddata;
   } vec_t;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [31:0] Z   = 32'h0;
   localparam logic [31:0] IA0 = 32'h0000_0040;
   localparam logic [31:0] DA0 = 32'h0000_2000;
   localparam logic [31:0] DV0 = 32'hCAFE_F00D;
   localparam logic [31:0] IA1 = 32'h0000_0100;
   localparam logic [31:0] DA1 = 32'h0000_3000;
   localparam logic [31:0] DV1 = 32'h55AA_55AA;
   localparam logic [31:0] IA2 = 32'h0000_0200;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      i_access = 1'b0; i_addr = 32'h0; d_access = 1'b0; d_addr = 32'h0;
      d_wr_en = 1'b0; d_wr_val = 32'h0; d_bytesel = 4'h0;
      m_data = 32'h0; m_ack = 1'b0; m_error = 1'b0;
   endtask

   // D store to a silent slave; the watchdog must answer in cycle G+4, or the late ack wins.
   task automatic run_timeout(input logic with_ack);
      @(negedge clk);
      d_access = 1'b1; d_addr = 32'h0000_4000; d_wr_en = 1'b1; d_wr_val = 32'h1234_5678;
      d_bytesel = 4'hF; m_ack = 1'b0; m_error = 1'b0; m_data = 32'h0;
      #2 chk("to_req_idle", {31'h0, m_access}, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #2;
         chk($sformatf("to_wait%0d_macc", k), {31'h0, m_access}, 32'h1);
         chk($sformatf("to_wait%0d_derr", k), {31'h0, d_error}, 32'h0);
      end
      @(negedge clk);
      if (with_ack) begin
         m_ack = 1'b1; m_data = 32'h9999_0000;
      end else begin
         m_ack = 1'b0;
      end
      #2;
      chk("to_fire_macc", {31'h0, m_access}, 32'h1);
      chk("to_fire_derr", {31'h0, d_error}, {31'h0, ~with_ack});
      chk("to_fire_dack", {31'h0, d_ack}, {31'h0, with_ack});
      chk("to_fire_ierr", {31'h0, i_error}, 32'h0);
      @(negedge clk);
      d_access = 1'b0; m_ack = 1'b0; m_data = 32'h0;
      #2;
      chk("to_after_macc", {31'h0, m_access}, 32'h0);
      chk("to_after_mwe", {31'h0, m_wr_en}, 32'h0);
      chk("to_after_derr", {31'h0, d_error}, 32'h0);
   endtask

   initial begin
      // contention after reset: I, D, I, D with one idle cycle between grants
      vecs[0]  = '{H,IA0,H,DA0,H,DV0,4'h3, Z,L,L,              L,Z,  L,Z,  4'h0, L,L,Z,            L,L,Z};
      vecs[1]  = '{H,IA0,H,DA0,H,DV0,4'h3, 32'h1111_1111,H,L,  H,IA0,L,Z,  4'hF, H,L,32'h1111_1111, L,L,Z};
      vecs[2]  = '{H,IA0,H,DA0,H,DV0,4'h3, Z,L,L,              L,IA0,L,Z,  4'hF, L,L,Z,            L,L,Z};
      vecs[3]  = '{H,IA0,H,DA0,H,DV0,4'h3, 32'h2222_2222,H,L,  H,DA0,H,DV0,4'h3, L,L,Z,            H,L,32'h2222_2222};
      vecs[4]  = '{H,IA0,H,DA0,H,DV0,4'h3, Z,L,L,              L,DA0,L,DV0,4'h3, L,L,Z,            L,L,Z};
      vecs[5]  = '{H,IA0,H,DA0,H,DV0,4'h3, 32'h3333_3333,H,L,  H,IA0,L,Z,  4'hF, H,L,32'h3333_3333, L,L,Z};
      vecs[6]  = '{L,IA0,H,DA0,H,DV0,4'h3, Z,L,L,              L,IA0,L,Z,  4'hF, L,L,Z,            L,L,Z};
      vecs[7]  = '{L,IA0,H,DA0,H,DV0,4'h3, 32'h4444_4444,H,L,  H,DA0,H,DV0,4'h3, L,L,Z,            H,L,32'h4444_4444};
      // single fetch, slave acks two cycles after m_access rises
      vecs[8]  = '{H,IA1,L,DA0,H,DV0,4'h3, Z,L,L,              L,DA0,L,DV0,4'h3, L,L,Z,            L,L,Z};
      vecs[9]  = '{H,IA1,L,DA0,H,DV0,4'h3, Z,L,L,              H,IA1,L,Z,  4'hF, L,L,Z,            L,L,Z};
      vecs[10] = '{H,IA1,L,DA0,H,DV0,4'h3, Z,L,L,              H,IA1,L,Z,  4'hF, L,L,Z,            L,L,Z};
      vecs[11] = '{H,IA1,L,DA0,H,DV0,4'h3, 32'hDEAD_BEEF,H,L,  H,IA1,L,Z,  4'hF, H,L,32'hDEAD_BEEF, L,L,Z};
      vecs[12] = '{L,IA1,L,DA0,H,DV0,4'h3, Z,L,L,              L,IA1,L,Z,  4'hF, L,L,Z,            L,L,Z};
      // D load answered by a slave error
      vecs[13] = '{L,IA1,H,DA1,L,DV1,4'hC, Z,L,L,              L,IA1,L,Z,  4'hF, L,L,Z,            L,L,Z};
      vecs[14] = '{L,IA1,H,DA1,L,DV1,4'hC, 32'h7777_7777,L,H,  H,DA1,L,DV1,4'hC, L,L,Z,            L,H,32'h7777_7777};
      vecs[15] = '{L,IA1,L,DA1,L,DV1,4'hC, Z,L,L,              L,DA1,L,DV1,4'hC, L,L,Z,            L,L,Z};
      // ack and error together: ack only
      vecs[16] = '{H,IA2,L,DA1,L,DV1,4'hC, Z,L,L,              L,DA1,L,DV1,4'hC, L,L,Z,            L,L,Z};
      vecs[17] = '{H,IA2,L,DA1,L,DV1,4'hC, 32'h8888_8888,H,H,  H,IA2,L,Z,  4'hF, H,L,32'h8888_8888, L,L,Z};
      vecs[18] = '{L,IA2,L,DA1,L,DV1,4'hC, Z,L,L,              L,IA2,L,Z,  4'hF, L,L,Z,            L,L,Z};

      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      chk("rst_macc", {31'h0, m_access}, 32'h0);
      chk("rst_maddr", m_addr, 32'h0);
      chk("rst_mbs", {28'h0, m_bytesel}, 32'h0);
      chk("rst_iack", {31'h0, i_ack}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         i_access = vecs[i].ia; i_addr = vecs[i].iaddr; d_access = vecs[i].da;
         d_addr = vecs[i].daddr; d_wr_en = vecs[i].dwe; d_wr_val = vecs[i].dwv;
         d_bytesel = vecs[i].dbs; m_data = vecs[i].mdata; m_ack = vecs[i].mack;
         m_error = vecs[i].merr;
         #2;
         chk($sformatf("v%0d_macc", i), {31'h0, m_access}, {31'h0, vecs[i].macc});
         chk($sformatf("v%0d_maddr", i), m_addr, vecs[i].maddr);
         chk($sformatf("v%0d_mwe", i), {31'h0, m_wr_en}, {31'h0, vecs[i].mwe});
         chk($sformatf("v%0d_mwv", i), m_wr_val, vecs[i].mwv);
         chk($sformatf("v%0d_mbs", i), {28'h0, m_bytesel}, {28'h0, vecs[i].mbs});
         chk($sformatf("v%0d_iack", i), {31'h0, i_ack}, {31'h0, vecs[i].iack});
         chk($sformatf("v%0d_ierr", i), {31'h0, i_error}, {31'h0, vecs[i].ierr});
         chk($sformatf("v%0d_idata", i), i_data, vecs[i].idata);
         chk($sformatf("v%0d_dack", i), {31'h0, d_ack}, {31'h0, vecs[i].dack});
         chk($sformatf("v%0d_derr", i), {31'h0, d_error}, {31'h0, vecs[i].derr});
         chk($sformatf("v%0d_ddata", i), d_data, vecs[i].ddata);
      end

      run_timeout(1'b0);
      run_timeout(1'b1);

      // asynchronous reset while a D store is granted
      @(negedge clk);
      drive_idle();
      d_access = 1'b1; d_addr = 32'h0000_6000; d_wr_en = 1'b1; d_wr_val = 32'hA5A5_A5A5;
      d_bytesel = 4'h1;
      @(negedge clk);
      #2;
      chk("mid_grant_macc", {31'h0, m_access}, 32'h1);
      chk("mid_grant_mwe", {31'h0, m_wr_en}, 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_macc", {31'h0, m_access}, 32'h0);
      chk("mid_rst_mwe", {31'h0, m_wr_en}, 32'h0);
      chk("mid_rst_maddr", m_addr, 32'h0);
      i_access = 1'b1; i_addr = 32'h0000_0500;
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("post_rst_idle", {31'h0, m_access}, 32'h0);
      @(negedge clk);
      #2;
      chk("post_rst_macc", {31'h0, m_access}, 32'h1);
      chk("post_rst_first_i", m_addr, 32'h0000_0500);
      chk("post_rst_mbs", {28'h0, m_bytesel}, 32'hF);
      chk("post_rst_mwe", {31'h0, m_wr_en}, 32'h0);
      m_ack = 1'b1;
      @(negedge clk);
      drive_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
